wm8731_i2c_responder: RTL and testbench

//   Synthesizable I2C target modelling the WM8731 control port: the receiving end of the codec config master.

---
 rtl/wm8731_pkg.sv | 40 ++++
 rtl/wm8731_i2c_responder_filter.sv | 104 ++++++++++
 rtl/wm8731_i2c_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_wm8731_i2c_responder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 control-port responder.
// Holds the register-file geometry, the reset-register address, the codec
// power-on default table and the frame-decoder state encoding.
`timescale 1ns/1ps
package wm8731_pkg;

  localparam int         WM_NUM_REGS  = 10;
  localparam logic [6:0] WM_RESET_REG = 7'h0F;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ACK_A     = 3'd2,
    ST_BYTE1     = 3'd3,
    ST_ACK_1     = 3'd4,
    ST_BYTE2     = 3'd5,
    ST_ACK_2     = 3'd6,
    ST_WAIT_STOP = 3'd7
  } wm_state_e;

  // Codec power-on value of register idx (R0..R9); anything else reads as zero.
  function automatic logic [8:0] wm_default(input logic [3:0] idx);
    logic [8:0] val;
    case (idx)
      4'd0:    val = 9'h097;
      4'd1:    val = 9'h097;
      4'd2:    val = 9'h079;
      4'd3:    val = 9'h079;
      4'd4:    val = 9'h00A;
      4'd5:    val = 9'h008;
      4'd6:    val = 9'h09F;
      4'd7:    val = 9'h00A;
      4'd8:    val = 9'h000;
      4'd9:    val = 9'h000;
      default: val = 9'h000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/wm8731_i2c_responder_filter.sv
// i2c_line_filter: synchroniser + glitch filter + edge/START/STOP detection
// for both I2C lines.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   scl_in, sda_in      raw bus levels
//   sda_level           filtered SDA level (bit value sampled on scl_rise)
//   scl_rise, scl_fall  one-clock pulses on filtered SCL edges
//   start_det, stop_det one-clock pulses on START / STOP
// A new level is accepted once FILTER_LEN consecutive synchronised samples
// agree; pulses are registered alongside the level they describe, so every
// event appears SYNC_STAGES+FILTER_LEN clocks after the line moved.
`timescale 1ns/1ps
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  // The newest sample comes straight from the synchroniser, so the history
  // only needs FILTER_LEN-1 older entries to form a FILTER_LEN-deep window.
  logic [FILTER_LEN-2:0]  scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic [FILTER_LEN-1:0]  scl_win_s, sda_win_s;
  logic scl_lvl_q, scl_lvl_d, sda_lvl_q, sda_lvl_d;
  logic scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
  logic start_q, start_d, stop_q, stop_d;

  // Next-state for synchronisers, filter windows, levels and event pulses.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_hist_d = {scl_hist_q[FILTER_LEN-3:0], scl_sync_q[SYNC_STAGES-1]};
    sda_hist_d = {sda_hist_q[FILTER_LEN-3:0], sda_sync_q[SYNC_STAGES-1]};
    scl_win_s  = {scl_hist_q, scl_sync_q[SYNC_STAGES-1]};
    sda_win_s  = {sda_hist_q, sda_sync_q[SYNC_STAGES-1]};

    scl_lvl_d = scl_lvl_q;
    if (&scl_win_s) begin
      scl_lvl_d = 1'b1;
    end else if (~|scl_win_s) begin
      scl_lvl_d = 1'b0;
    end else begin
      scl_lvl_d = scl_lvl_q;
    end

    sda_lvl_d = sda_lvl_q;
    if (&sda_win_s) begin
      sda_lvl_d = 1'b1;
    end else if (~|sda_win_s) begin
      sda_lvl_d = 1'b0;
    end else begin
      sda_lvl_d = sda_lvl_q;
    end

    scl_rise_d = ~scl_lvl_q & scl_lvl_d;
    scl_fall_d = scl_lvl_q & ~scl_lvl_d;
    // SDA moving while SCL is steadily high is a bus condition, not data.
    start_d = scl_lvl_q & scl_lvl_d & sda_lvl_q & ~sda_lvl_d;
    stop_d  = scl_lvl_q & scl_lvl_d & ~sda_lvl_q & sda_lvl_d;
  end

  // Filter state registers; an idle bus is high on both lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_hist_q <= {(FILTER_LEN-1){1'b1}};
      sda_hist_q <= {(FILTER_LEN-1){1'b1}};
      scl_lvl_q  <= 1'b1;
      sda_lvl_q  <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_lvl_q  <= scl_lvl_d;
      sda_lvl_q  <= sda_lvl_d;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign sda_level = sda_lvl_q;
  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;

endmodule

// File: rtl/wm8731_i2c_responder.sv
// wm8731_i2c_responder: I2C write-only target modelling the WM8731 control port.
// Ports:
//   clock, reset      system clock (>= 16x SCL), synchronous active-high reset
//   I2C_SCLK          bus clock from the master
//   I2C_SDAT          bus data; pulled low only while ACKing
//   rd_addr/rd_data   combinational shadow-register readback
//   wr_strobe         one-clock pulse per committed write (incl. reset register)
//   wr_addr/wr_data   address/data of the last commit
//   busy              START seen and no STOP/reset since
//   err_flag          sticky error (bad register, read request, short frame)
// Frames are {dev+W, reg[6:0]+data[8], data[7:0]}; the commit happens on the
// SCL fall that ends the third ACK.
`timescale 1ns/1ps
module wm8731_i2c_responder
  import wm8731_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       busy,
  output logic       err_flag
);

  logic sda_lvl_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  i2c_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk      (clock),
    .reset    (reset),
    .scl_in   (I2C_SCLK),
    .sda_in   (I2C_SDAT),
    .sda_level(sda_lvl_s),
    .scl_rise (scl_rise_s),
    .scl_fall (scl_fall_s),
    .start_det(start_s),
    .stop_det (stop_s)
  );

  wm_state_e  state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte1_q, byte1_d;
  logic       sda_oe_q, sda_oe_d;
  // Set once our address was ACKed for a write; a STOP while set is a short frame.
  logic       frame_open_q, frame_open_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [8:0] wr_data_q, wr_data_d;
  logic [8:0] regs_q [WM_NUM_REGS];
  logic [8:0] regs_d [WM_NUM_REGS];
  logic [6:0] c_reg_s;
  logic [8:0] c_data_s;

  // Frame decoder next-state: bus conditions override everything else.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte1_d      = byte1_q;
    sda_oe_d     = sda_oe_q;
    frame_open_d = frame_open_q;
    busy_d       = busy_q;
    err_d        = err_q;
    wr_strobe_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    regs_d       = regs_q;
    // During ACK_2 the shift register still holds the second data byte.
    c_reg_s      = byte1_q[7:1];
    c_data_s     = {byte1_q[0], shift_q};

    if (start_s) begin
      state_d      = ST_ADDR;
      bit_cnt_d    = 4'd0;
      sda_oe_d     = 1'b0;
      busy_d       = 1'b1;
      frame_open_d = 1'b0;
    end else if (stop_s) begin
      state_d      = ST_IDLE;
      sda_oe_d     = 1'b0;
      busy_d       = 1'b0;
      frame_open_d = 1'b0;
      if (frame_open_q) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      case (state_q)
        ST_ADDR, ST_BYTE1, ST_BYTE2: begin
          if (scl_rise_s) begin
            shift_d   = {shift_q[6:0], sda_lvl_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
            // Byte complete: decide the ACK on the fall that opens the 9th clock.
            bit_cnt_d = 4'd0;
            case (state_q)
              ST_ADDR: begin
                if (shift_q[7:1] != DEV_ADDR) begin
                  state_d = ST_WAIT_STOP;
                end else if (shift_q[0]) begin
                  err_d   = 1'b1;
                  state_d = ST_WAIT_STOP;
                end else begin
                  state_d      = ST_ACK_A;
                  sda_oe_d     = 1'b1;
                  frame_open_d = 1'b1;
                end
              end
              ST_BYTE1: begin
                byte1_d  = shift_q;
                state_d  = ST_ACK_1;
                sda_oe_d = 1'b1;
              end
              ST_BYTE2: begin
                state_d  = ST_ACK_2;
                sda_oe_d = 1'b1;
              end
              default: state_d = ST_WAIT_STOP;
            endcase
          end else begin
            state_d = state_q;
          end
        end
        ST_ACK_A, ST_ACK_1: begin
          if (scl_fall_s) begin
            sda_oe_d = 1'b0;
            state_d  = (state_q == ST_ACK_A) ? ST_BYTE1 : ST_BYTE2;
          end else begin
            state_d = state_q;
          end
        end
        ST_ACK_2: begin
          if (scl_fall_s) begin
            sda_oe_d     = 1'b0;
            state_d      = ST_WAIT_STOP;
            frame_open_d = 1'b0;
            if (int'(c_reg_s) < WM_NUM_REGS) begin
              regs_d[c_reg_s[3:0]] = c_data_s;
              wr_strobe_d          = 1'b1;
              wr_addr_d            = c_reg_s;
              wr_data_d            = c_data_s;
            end else if (c_reg_s == WM_RESET_REG) begin
              for (int i = 0; i < WM_NUM_REGS; i++) begin
                regs_d[i] = wm_default(4'(i));
              end
              wr_strobe_d = 1'b1;
              wr_addr_d   = c_reg_s;
              wr_data_d   = 9'h000;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_IDLE, ST_WAIT_STOP: state_d = state_q;
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Decoder, output and register-file flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      byte1_q      <= 8'h00;
      sda_oe_q     <= 1'b0;
      frame_open_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= 7'h00;
      wr_data_q    <= 9'h000;
      for (int i = 0; i < WM_NUM_REGS; i++) begin
        regs_q[i] <= wm_default(4'(i));
      end
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte1_q      <= byte1_d;
      sda_oe_q     <= sda_oe_d;
      frame_open_q <= frame_open_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      for (int i = 0; i < WM_NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Readback: indices past the implemented registers read as zero.
  always_comb begin
    rd_data = 9'h000;
    if (int'(rd_addr) < WM_NUM_REGS) begin
      rd_data = regs_q[rd_addr];
    end else begin
      rd_data = 9'h000;
    end
  end

  assign I2C_SDAT  = sda_oe_q ? 1'b0 : 1'bz;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign err_flag  = err_q;

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Directed bench for wm8731_i2c_responder. A bit-banged I2C master drives
// frames; expected commits are queued by the stimulus and checked by a
// separate strobe monitor, while ACKs, flags and readback are checked inline.
`timescale 1ns/1ps
module tb_wm8731_i2c_responder;

  localparam int T = 20;   // clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;   // 1 = master releases SDA
  wire        sdat;
  logic [3:0] rd_addr = 4'd0;
  wire  [8:0] rd_data;
  wire        wr_strobe;
  wire  [6:0] wr_addr;
  wire  [8:0] wr_data;
  wire        busy;
  wire        err_flag;

  assign sdat = m_sda ? 1'bz : 1'b0;
  pullup (sdat);

  always #5 clk = ~clk;

  wm8731_i2c_responder dut (
    .clock    (clk),
    .reset    (rst),
    .I2C_SCLK (m_scl),
    .I2C_SDAT (sdat),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .err_flag (err_flag)
  );

  int n_pass  = 0;
  int n_total = 0;
  int dut_low_cnt = 0;

  typedef struct {
    logic [6:0] a;
    logic [8:0] d;
    bit         chk_d;
  } wr_t;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Strobe monitor: every commit pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_strobe: wr_addr=%0h wr_data=%0h, none expected", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {25'd0, wr_addr}, {25'd0, e.a});
        if (e.chk_d) check("wr_data", {23'd0, wr_data}, {23'd0, e.d});
      end
    end
  end

  // Counts clocks where someone other than the master holds SDAT low.
  always @(negedge clk) begin
    if (m_sda && (sdat === 1'b0)) dut_low_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    if (!m_scl) begin
      m_sda = 1'b1; tick(T);
      m_scl = 1'b1; tick(T);
    end
    m_sda = 1'b0; tick(T);
    m_scl = 1'b0; tick(T);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(T);
    m_scl = 1'b1; tick(T);
    m_sda = 1'b1; tick(2 * T);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    m_sda = b; tick(T / 2);
    if (glitch) begin m_scl = 1'b1; tick(1); m_scl = 1'b0; end
    tick(T / 2);
    m_scl = 1'b1; tick(T);
    if (glitch) begin m_scl = 1'b0; tick(1); m_scl = 1'b1; end
    tick(T);
    m_scl = 1'b0; tick(T);
  endtask

  task automatic ack_bit(input bit exp_ack, input string name);
    m_sda = 1'b1; tick(T);
    m_scl = 1'b1; tick(T);
    check(name, {31'd0, sdat}, exp_ack ? 32'd0 : 32'd1);
    tick(T);
    m_scl = 1'b0; tick(T);
    check({name, "_release"}, {31'd0, sdat}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack, input string name);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
    ack_bit(exp_ack, name);
  endtask

  task automatic rd_check(input logic [3:0] a, input logic [8:0] exp, input string name);
    rd_addr = a;
    #1;
    check(name, {23'd0, rd_data}, {23'd0, exp});
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(4);
    rst = 1'b0; tick(10);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err_flag}, 32'd0);
    check("rst_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {23'd0, wr_data}, 32'd0);
    check("rst_sdat", {31'd0, sdat}, 32'd1);
    rd_check(4'd0, 9'h097, "rst_r0");
    rd_check(4'd2, 9'h079, "rst_r2");
    rd_check(4'd4, 9'h00A, "rst_r4");
    rd_check(4'd6, 9'h09F, "rst_r6");
    rd_check(4'd12, 9'h000, "rd_r12");
    rd_check(4'd15, 9'h000, "rd_r15");

    // Wrong device address: never pulled low, nothing written
    dut_low_cnt = 0;
    i2c_start();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    send_byte(8'h36, 1'b0, "wa_ack_addr");
    send_byte(8'h08, 1'b0, "wa_ack_b1");
    send_byte(8'h12, 1'b0, "wa_ack_b2");
    i2c_stop();
    check("wa_sdat_low_clocks", dut_low_cnt, 32'd0);
    check("wa_busy", {31'd0, busy}, 32'd0);
    check("wa_err", {31'd0, err_flag}, 32'd0);
    rd_check(4'd4, 9'h00A, "wa_r4");

    // Good write to R4
    exp_q.push_back('{7'h04, 9'h012, 1'b1});
    i2c_start();
    send_byte(8'h34, 1'b1, "w4_ack_addr");
    send_byte(8'h08, 1'b1, "w4_ack_b1");
    send_byte(8'h12, 1'b1, "w4_ack_b2");
    i2c_stop();
    check("w4_strobes_done", exp_q.size(), 32'd0);
    rd_check(4'd4, 9'h012, "w4_r4");
    check("w4_err", {31'd0, err_flag}, 32'd0);
    check("w4_busy", {31'd0, busy}, 32'd0);

    // R9 with data bit 8 set, then the reset register
    exp_q.push_back('{7'h09, 9'h100, 1'b1});
    i2c_start();
    send_byte(8'h34, 1'b1, "w9_ack_addr");
    send_byte(8'h13, 1'b1, "w9_ack_b1");
    send_byte(8'h00, 1'b1, "w9_ack_b2");
    i2c_stop();
    rd_check(4'd9, 9'h100, "w9_r9");
    exp_q.push_back('{7'h0F, 9'h000, 1'b0});
    i2c_start();
    send_byte(8'h34, 1'b1, "wr15_ack_addr");
    send_byte(8'h1E, 1'b1, "wr15_ack_b1");
    send_byte(8'h00, 1'b1, "wr15_ack_b2");
    i2c_stop();
    check("wr15_strobes_done", exp_q.size(), 32'd0);
    rd_check(4'd9, 9'h000, "wr15_r9");
    rd_check(4'd4, 9'h00A, "wr15_r4");
    check("wr15_err", {31'd0, err_flag}, 32'd0);

    // Short frame: STOP after the register byte
    i2c_start();
    send_byte(8'h34, 1'b1, "sf_ack_addr");
    send_byte(8'h08, 1'b1, "sf_ack_b1");
    i2c_stop();
    check("sf_err", {31'd0, err_flag}, 32'd1);
    rd_check(4'd4, 9'h00A, "sf_r4");

    // Reset clears the sticky error; repeated START abandons the first frame
    do_reset();
    check("rs_err_cleared", {31'd0, err_flag}, 32'd0);
    exp_q.push_back('{7'h02, 9'h079, 1'b1});
    i2c_start();
    send_byte(8'h34, 1'b1, "rs_ack_addr0");
    send_byte(8'h08, 1'b1, "rs_ack_b1_0");
    i2c_start();
    send_byte(8'h34, 1'b1, "rs_ack_addr1");
    send_byte(8'h04, 1'b1, "rs_ack_b1_1");
    send_byte(8'h79, 1'b1, "rs_ack_b2_1");
    i2c_stop();
    check("rs_strobes_done", exp_q.size(), 32'd0);
    rd_check(4'd2, 9'h079, "rs_r2");
    rd_check(4'd4, 9'h00A, "rs_r4");
    check("rs_err", {31'd0, err_flag}, 32'd0);

    // Read request: not ACKed, flagged, further bytes ignored
    i2c_start();
    send_byte(8'h35, 1'b0, "rd_ack_addr");
    send_byte(8'h00, 1'b0, "rd_ack_b1");
    i2c_stop();
    check("rd_err", {31'd0, err_flag}, 32'd1);

    // Unimplemented register 10: ACKed, no strobe, flagged
    do_reset();
    i2c_start();
    send_byte(8'h34, 1'b1, "r10_ack_addr");
    send_byte(8'h14, 1'b1, "r10_ack_b1");
    send_byte(8'h55, 1'b1, "r10_ack_b2");
    i2c_stop();
    check("r10_err", {31'd0, err_flag}, 32'd1);

    // One-clock SCLK glitches inside the register byte are ignored
    do_reset();
    exp_q.push_back('{7'h04, 9'h012, 1'b1});
    i2c_start();
    send_byte(8'h34, 1'b1, "gl_ack_addr");
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] b;
      b = 8'h08;
      send_bit(b[i], (i == 5) || (i == 3));
    end
    ack_bit(1'b1, "gl_ack_b1");
    send_byte(8'h12, 1'b1, "gl_ack_b2");
    i2c_stop();
    check("gl_strobes_done", exp_q.size(), 32'd0);
    rd_check(4'd4, 9'h012, "gl_r4");
    check("gl_err", {31'd0, err_flag}, 32'd0);

    // Reset in the middle of the data byte: IDLE, SDAT released, defaults back
    i2c_start();
    send_byte(8'h34, 1'b1, "mr_ack_addr");
    send_byte(8'h08, 1'b1, "mr_ack_b1");
    for (int i = 7; i >= 4; i--) begin
      logic [7:0] b;
      b = 8'h12;
      send_bit(b[i], 1'b0);
    end
    rst = 1'b1; tick(3);
    #1;
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_sdat", {31'd0, sdat}, 32'd1);
    check("mr_err", {31'd0, err_flag}, 32'd0);
    rd_check(4'd4, 9'h00A, "mr_r4");
    rst = 1'b0; tick(10);
    i2c_stop();
    check("mr_busy_end", {31'd0, busy}, 32'd0);
    check("mr_err_end", {31'd0, err_flag}, 32'd0);
    check("mr_strobes_done", exp_q.size(), 32'd0);

    tick(20);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
